// File: rtl/booth_r4_pp_acc.sv
// booth_r4_pp_acc: iterative radix-4 Booth partial-product generator with a
// carry-save accumulator. One Booth digit is retired per RUN cycle; the
// redundant {pp_sum, pp_carry} pair is resolved by the downstream adder.
// Optional build macro: BOOTH_EARLY_EXIT_EN (finish as soon as every remaining
// multiplier digit is zero).
module booth_r4_pp_acc #(
  parameter int WIDTH = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] pp_sum,
  output logic [2*WIDTH-1:0] pp_carry,
  output logic               busy
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [CW-1:0]   cnt_r;
  logic [W2-1:0]   mcand_sh_r;   // sign-extended multiplicand, pre-shifted by 2i
  logic [WIDTH:0]  mplr_sh_r;    // {mplr,0} arithmetic-shifted right by 2i
  logic [W2-1:0]   sum_r;
  logic [W2-1:0]   carry_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;

  logic            accept_s;
  logic            acc_en_s;
  logic            last_s;
  logic [2:0]      dig_s;        // {neg, two, one}
  logic [W2-1:0]   pp_s;
  logic [W2-1:0]   maj_s;
  logic [W2-1:0]   sum_nx_s;
  logic [W2-1:0]   carry_nx_s;

  // Radix-4 Booth recoding of one overlapping bit triple into {neg, two, one}.
  function automatic logic [2:0] booth_decode(input logic [2:0] trip);
    case (trip)
      3'b000, 3'b111: booth_decode = 3'b000;
      3'b001, 3'b010: booth_decode = 3'b001;
      3'b011:         booth_decode = 3'b010;
      3'b100:         booth_decode = 3'b110;
      3'b101, 3'b110: booth_decode = 3'b101;
      default:        booth_decode = 3'b000;
    endcase
  endfunction

  // Partial-product selection and 3:2 compression into the next sum/carry.
  always_comb begin
    dig_s = booth_decode(mplr_sh_r[2:0]);
    pp_s  = {W2{1'b0}};
    if (dig_s[0]) begin
      pp_s = mcand_sh_r;
    end else if (dig_s[1]) begin
      pp_s = {mcand_sh_r[W2-2:0], 1'b0};
    end else begin
      pp_s = {W2{1'b0}};
    end
    // Negation: invert here, the +1 lands in the free carry bit 0 below.
    if (dig_s[2]) begin
      pp_s = ~pp_s;
    end else begin
      pp_s = pp_s;
    end
    sum_nx_s   = sum_r ^ carry_r ^ pp_s;
    maj_s      = (sum_r & carry_r) | (sum_r & pp_s) | (carry_r & pp_s);
    carry_nx_s = {maj_s[W2-2:0], dig_s[2]};
  end

  // Next-state logic: accept in IDLE, one digit per RUN cycle, hold in DONE.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    acc_en_s   = 1'b0;
    last_s     = (cnt_r == LAST_IDX);
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s   = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
`ifdef BOOTH_EARLY_EXIT_EN
        // Remaining bits all equal means every remaining digit is zero.
        if ((&mplr_sh_r) || !(|mplr_sh_r)) begin
          state_nx_s = DONE;
        end else begin
          acc_en_s = 1'b1;
          if (last_s) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = RUN;
          end
        end
`else
        acc_en_s = 1'b1;
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
      busy_r      <= (state_nx_s != IDLE);
    end
  end

  // Operand capture, per-digit shifting, counter and accumulator update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CW{1'b0}};
      mcand_sh_r <= {W2{1'b0}};
      mplr_sh_r  <= {(WIDTH+1){1'b0}};
      sum_r      <= {W2{1'b0}};
      carry_r    <= {W2{1'b0}};
    end else if (accept_s) begin
      cnt_r      <= {CW{1'b0}};
      mcand_sh_r <= {{WIDTH{mcand[WIDTH-1]}}, mcand};
      mplr_sh_r  <= {mplr, 1'b0};
      sum_r      <= {W2{1'b0}};
      carry_r    <= {W2{1'b0}};
    end else if (state_r == RUN) begin
      cnt_r      <= cnt_r + CNT_ONE;
      mcand_sh_r <= {mcand_sh_r[W2-3:0], 2'b00};
      mplr_sh_r  <= {{2{mplr_sh_r[WIDTH]}}, mplr_sh_r[WIDTH:2]};
      if (acc_en_s) begin
        sum_r   <= sum_nx_s;
        carry_r <= carry_nx_s;
      end else begin
        sum_r   <= sum_r;
        carry_r <= carry_r;
      end
    end else begin
      cnt_r      <= cnt_r;
      mcand_sh_r <= mcand_sh_r;
      mplr_sh_r  <= mplr_sh_r;
      sum_r      <= sum_r;
      carry_r    <= carry_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign pp_sum    = sum_r;
  assign pp_carry  = carry_r;

endmodule
